conv3x3_cfg: RTL and testbench
==============================

// Module: conv3x3_cfg
// PURPOSE
//  Parametrised 3x3 convolution engine; next generation of the fixed-kernel image filter stage.
//  Takes one 3x3 pixel window per valid cycle from the line-buffer and emits one filtered pixel.
//  Kernel, normalisation shift and output mode are loaded at run time into a shadow bank.
//  The shadow bank is committed atomically, so the filter can be switched between frames.
// PARAMETERS
//  PIX_W    8  pixel width, unsigned
//  COEF_W   8  coefficient width, two's complement
//  SHIFT_W  4  width of the normalisation right-shift amount
// PORTS
//  i_clk                  in   1          clock
//  i_rst                  in   1          reset, asynchronous, active-high
//  i_pixel_data           in   9*PIX_W    window; pixel k at [k*PIX_W +: PIX_W], k=0..8 row-major, k=4 centre
//  i_pixel_data_valid     in   1          window valid
//  i_coef_wr              in   1          shadow-bank write strobe
//  i_coef_addr            in   4          0-8 coef k; 9 shift; 10 mode; 11-15 ignored
//  i_coef_data            in   COEF_W     write data (shift uses [SHIFT_W-1:0], mode uses [1:0])
//  i_coef_commit          in   1          pulse: copy shadow bank to active bank
//  o_convolved_data       out  PIX_W      filtered pixel
//  o_convolved_data_valid out  1          output valid
//  o_cfg_dirty            out  1          shadow bank differs from last commit
// BEHAVIOUR
//  Reset (async, i_rst=1): all valids 0, o_convolved_data 0, o_cfg_dirty 0.
//   Both banks load sharpen {0,-1,0,-1,5,-1,0,-1,0}, shift 0, mode 0.
//  Config writes: on i_coef_wr, shadow[addr] <= data. Addr 11-15 are a no-op and do not set dirty.
//   A valid write sets o_cfg_dirty the next cycle.
//  Commit: on i_coef_commit, active <= shadow and o_cfg_dirty <= 0.
//   If write and commit occur in the same cycle, the write is included in the commit.
//   A window is clocked into S1 on cycle N using the bank active during cycle N.
//   A commit in cycle N affects windows entering on N+1 onward.
//  No stall/backpressure: a window is accepted every cycle i_pixel_data_valid=1.
//  Pipeline; valid travels with data; latency is exactly 4 cycles (in at N -> out at N+4):
//   S1: prod[k] = signed(coef[k]) * signed({1'b0,pix[k]}), width PIX_W+COEF_W+1.
//       Shift and mode from the active bank are also registered into S1.
//   S2: signed sum of 9 products, width PIX_W+COEF_W+5 (no overflow possible).
//   S3: if shift>0, add 2^(shift-1) (round half up), then arithmetic right shift.
//   S4: mode[1]=1 bypass: output centre pixel delayed 4 cycles, unmodified.
//       Else mode[0]=1 takes the absolute value, then clamps to [0, 2^PIX_W-1].
//  Shift and mode travel with their window through S1-S4.
//   A commit never alters in-flight results.
//  Output data holds its last value when valid is 0; the bench checks data only when valid=1.
//  Reset asserted mid-stream flushes all in-flight data; no output valid until new input.
// TESTING
//  1 Reset defaults, flat window all 100, valid 1 cycle -> one valid out 4 cycles later, data 100.
//  2 Default kernel, centre 255, others 0 -> 5*255 clamps to 255.
//    Centre 0, others 255 -> -1020 clamps to 0.
//  3 Load box kernel (all 1), shift 3, mode 0, commit; all pixels 200.
//    -> sum 1800 >>3 with round = 225. Check o_cfg_dirty 1 after writes, 0 after commit.
//  4 Laplacian {0,1,0,1,-4,1,0,1,0}, mode 1 (abs); centre 50, N/S/E/W 0 -> |-200| = 200.
//    Same kernel with mode 0 -> 0.
//  5 Continuous valid stream; commit box kernel mid-stream at cycle N.
//    -> windows entering <=N use sharpen, >N use box. Outputs are back-to-back with no gap.
//  6 Mode 2 (bypass) -> output equals centre pixel.
//    Assert i_rst with 3 windows in flight -> no valid out afterwards, banks back to sharpen.

Source files
------------

// File: rtl/conv3x3_cfg.sv
// 3x3 convolution engine with a run-time kernel held in shadow/active register banks.
// Four-stage pipeline: multiply, sum, round+shift, abs/clamp or centre-pixel bypass.
module conv3x3_cfg #(
  parameter int PIX_W   = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [9*PIX_W-1:0] i_pixel_data,
  input  logic               i_pixel_data_valid,
  input  logic               i_coef_wr,
  input  logic [3:0]         i_coef_addr,
  input  logic [COEF_W-1:0]  i_coef_data,
  input  logic               i_coef_commit,
  output logic [PIX_W-1:0]   o_convolved_data,
  output logic               o_convolved_data_valid,
  output logic               o_cfg_dirty
);

  localparam int PW = PIX_W + COEF_W + 1;
  localparam int SW = PIX_W + COEF_W + 5;
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

  function automatic logic signed [COEF_W-1:0] sharpen(input int unsigned k);
    if (k == 4)          return COEF_W'(5);
    else if (k % 2 == 1) return '1;
    else                 return '0;
  endfunction

  logic signed [COEF_W-1:0] sh_coef [9];
  logic signed [COEF_W-1:0] sh_coef_nx [9];
  logic signed [COEF_W-1:0] act_coef [9];
  logic [SHIFT_W-1:0]       sh_shift, sh_shift_nx, act_shift;
  logic [1:0]               sh_mode, sh_mode_nx, act_mode;
  logic                     wr_ok;

  assign wr_ok = i_coef_wr && (i_coef_addr <= 4'd10);

  // Shadow contents after this cycle's write; a same-cycle commit copies this view.
  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      sh_coef_nx[k] = sh_coef[k];
      if (wr_ok && i_coef_addr == 4'(k)) sh_coef_nx[k] = i_coef_data;
    end
    sh_shift_nx = (wr_ok && i_coef_addr == 4'd9)  ? i_coef_data[SHIFT_W-1:0] : sh_shift;
    sh_mode_nx  = (wr_ok && i_coef_addr == 4'd10) ? i_coef_data[1:0]         : sh_mode;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < 9; k++) begin
        sh_coef[k]  <= sharpen(k);
        act_coef[k] <= sharpen(k);
      end
      sh_shift    <= '0;
      act_shift   <= '0;
      sh_mode     <= '0;
      act_mode    <= '0;
      o_cfg_dirty <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 9; k++) begin
        sh_coef[k] <= sh_coef_nx[k];
        if (i_coef_commit) act_coef[k] <= sh_coef_nx[k];
      end
      sh_shift <= sh_shift_nx;
      sh_mode  <= sh_mode_nx;
      if (i_coef_commit) begin
        act_shift   <= sh_shift_nx;
        act_mode    <= sh_mode_nx;
        o_cfg_dirty <= 1'b0;
      end else if (wr_ok) begin
        o_cfg_dirty <= 1'b1;
      end
    end
  end

  logic signed [PW-1:0] prod1 [9];
  logic signed [SW-1:0] sum2, res3;
  logic [SHIFT_W-1:0]   shift1, shift2;
  logic [1:0]           mode1, mode2, mode3;
  logic [PIX_W-1:0]     centre1, centre2, centre3;
  logic                 v1, v2, v3;

  logic signed [SW-1:0] sum_c, rnd_c, rounded_c, mag_c;
  logic [PIX_W-1:0]     out_c;

  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < 9; k++) sum_c = sum_c + SW'(prod1[k]);
  end

  always_comb begin
    rnd_c     = (shift2 != '0) ? (SW'(1) <<< (shift2 - SHIFT_W'(1))) : '0;
    rounded_c = sum2 + rnd_c;
  end

  always_comb begin
    mag_c = (mode3[0] && res3 < 0) ? -res3 : res3;
    if (mode3[1])            out_c = centre3;
    else if (mag_c < 0)      out_c = '0;
    else if (mag_c > PIX_MAX) out_c = '1;
    else                     out_c = mag_c[PIX_W-1:0];
  end

  // Shift, mode and centre pixel ride alongside each window so commits never touch in-flight data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < 9; k++) prod1[k] <= '0;
      sum2    <= '0;
      res3    <= '0;
      shift1  <= '0;
      shift2  <= '0;
      mode1   <= '0;
      mode2   <= '0;
      mode3   <= '0;
      centre1 <= '0;
      centre2 <= '0;
      centre3 <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      o_convolved_data       <= '0;
      o_convolved_data_valid <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 9; k++)
        prod1[k] <= PW'(act_coef[k]) * PW'($signed({1'b0, i_pixel_data[k*PIX_W +: PIX_W]}));
      shift1  <= act_shift;
      mode1   <= act_mode;
      centre1 <= i_pixel_data[4*PIX_W +: PIX_W];
      v1      <= i_pixel_data_valid;

      sum2    <= sum_c;
      shift2  <= shift1;
      mode2   <= mode1;
      centre2 <= centre1;
      v2      <= v1;

      res3    <= rounded_c >>> shift2;
      mode3   <= mode2;
      centre3 <= centre2;
      v3      <= v2;

      if (v3) o_convolved_data <= out_c;
      o_convolved_data_valid <= v3;
    end
  end

endmodule

// File: tb/tb_conv3x3_cfg.sv
// Self-checking bench for conv3x3_cfg: directed scenarios plus random traffic
// compared against an integer-arithmetic reference of the filter and its config banks.
module tb_conv3x3_cfg;
  localparam int PIX_W = 8, COEF_W = 8, SHIFT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [9*PIX_W-1:0] pix;
  logic               pv, cw, cc;
  logic [3:0]         ca;
  logic [COEF_W-1:0]  cd;
  logic [PIX_W-1:0]   od;
  logic               ov, dirty;

  conv3x3_cfg #(.PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pixel_data(pix), .i_pixel_data_valid(pv),
    .i_coef_wr(cw), .i_coef_addr(ca), .i_coef_data(cd), .i_coef_commit(cc),
    .o_convolved_data(od), .o_convolved_data_valid(ov), .o_cfg_dirty(dirty)
  );

  int checks = 0, failures = 0, cyc = 0;
  int sh_coef [9], act_coef [9];
  int sh_shift, act_shift, sh_mode, act_mode;
  bit m_dirty;
  typedef struct { int due; int data; } exp_t;
  exp_t exp_q [$];

  function automatic int sharp(input int k);
    return (k == 4) ? 5 : ((k % 2 == 1) ? -1 : 0);
  endfunction

  function automatic int model_out(input logic [9*PIX_W-1:0] w);
    int acc = 0;
    for (int k = 0; k < 9; k++) acc += act_coef[k] * int'(w[k*PIX_W +: PIX_W]);
    if (act_shift > 0) acc = (acc + (1 << (act_shift - 1))) >>> act_shift;
    if ((act_mode & 2) != 0) return int'(w[4*PIX_W +: PIX_W]);
    if ((act_mode & 1) != 0 && acc < 0) acc = -acc;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Apply this cycle's inputs to the model, clock once, then check outputs.
  task automatic step();
    if (pv) exp_q.push_back(exp_t'{cyc + 4, model_out(pix)});
    if (cw && ca <= 4'd10) begin
      if (ca < 4'd9)       sh_coef[int'(ca)] = int'($signed(cd));
      else if (ca == 4'd9) sh_shift = int'(cd[SHIFT_W-1:0]);
      else                 sh_mode = int'(cd[1:0]);
      m_dirty = 1'b1;
    end
    if (cc) begin
      act_coef = sh_coef; act_shift = sh_shift; act_mode = sh_mode;
      m_dirty = 1'b0;
    end
    @(posedge clk); cyc++; #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("valid", 32'(ov), 1);
      check("data", 32'(od), exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check("valid_idle", 32'(ov), 0);
    end
    check("dirty", 32'(dirty), 32'(m_dirty));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; pv = 1'b0; cw = 1'b0; cc = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin sh_coef[k] = sharp(k); act_coef[k] = sharp(k); end
    sh_shift = 0; act_shift = 0; sh_mode = 0; act_mode = 0; m_dirty = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); cyc++; #1;
      check("rst_valid", 32'(ov), 0);
      check("rst_data", 32'(od), 0);
      check("rst_dirty", 32'(dirty), 0);
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    pv = 1'b0; cw = 1'b0; cc = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic win(input logic [9*PIX_W-1:0] w);
    pix = w; pv = 1'b1; step(); pv = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [COEF_W-1:0] d);
    cw = 1'b1; ca = a; cd = d; step(); cw = 1'b0;
  endtask

  task automatic commit();
    cc = 1'b1; step(); cc = 1'b0;
  endtask

  function automatic logic [9*PIX_W-1:0] flat(input logic [PIX_W-1:0] p);
    logic [9*PIX_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = p;
    return w;
  endfunction

  function automatic logic [9*PIX_W-1:0] rand_win();
    logic [9*PIX_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = PIX_W'($urandom);
    return w;
  endfunction

  initial begin
    logic [9*PIX_W-1:0] w;
    pix = '0; ca = '0; cd = '0;
    do_reset(3);

    // Flat 100 through the default sharpen kernel, single valid.
    win(flat(8'd100));
    idle(6);

    // Clamp high and clamp low.
    w = '0; w[4*PIX_W +: PIX_W] = 8'd255; win(w);
    w = flat(8'd255); w[4*PIX_W +: PIX_W] = 8'd0; win(w);
    idle(5);

    // Box kernel, shift 3, mode 0.
    for (int k = 0; k < 9; k++) wr(4'(k), 8'd1);
    wr(4'd9, 8'd3);
    wr(4'd10, 8'd0);
    wr(4'd12, 8'd77);
    commit();
    win(flat(8'd200));
    idle(5);

    // Laplacian with abs, then without.
    for (int k = 0; k < 9; k++) wr(4'(k), (k == 4) ? 8'hFC : ((k % 2 == 1) ? 8'd1 : 8'd0));
    wr(4'd9, 8'd0);
    wr(4'd10, 8'd1);
    commit();
    w = '0; w[4*PIX_W +: PIX_W] = 8'd50; win(w);
    wr(4'd10, 8'd0);
    commit();
    win(w);
    idle(5);

    // Mid-stream commit of the box kernel into a sharpen-configured engine.
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      pix = rand_win(); pv = 1'b1;
      if (i < 9)        begin cw = 1'b1; ca = 4'(i); cd = 8'd1; end
      else if (i == 9)  begin cw = 1'b1; ca = 4'd10; cd = 8'd0; end
      else if (i == 14) begin cw = 1'b1; ca = 4'd9; cd = 8'd3; cc = 1'b1; end
      step();
      cw = 1'b0; cc = 1'b0;
    end
    idle(5);

    // Bypass mode returns the centre pixel.
    wr(4'd10, 8'd2);
    commit();
    for (int i = 0; i < 6; i++) win(rand_win());

    // Reset with windows in flight flushes them and restores sharpen.
    for (int i = 0; i < 3; i++) begin pix = rand_win(); pv = 1'b1; step(); end
    pv = 1'b0;
    do_reset(2);
    idle(6);
    win(flat(8'd100));
    w = '0; w[4*PIX_W +: PIX_W] = 8'd40; w[1*PIX_W +: PIX_W] = 8'd10; win(w);
    idle(5);

    // Random traffic: config writes (incl. ignored addresses), commits and windows.
    for (int i = 0; i < 400; i++) begin
      pix = rand_win();
      pv  = ($urandom % 4) != 0;
      cw  = ($urandom % 3) == 0;
      ca  = 4'($urandom);
      cd  = COEF_W'($urandom);
      cc  = ($urandom % 12) == 0;
      step();
    end
    idle(8);
    check("drain", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
